load_store_unit: RTL

Memory-stage load/store unit between the pipeline's M stage and the data-memory bus. It takes the M-stage address (ALU result), store data and funct3, and runs a req/ack bus transaction. It stalls the pipeline until the transaction completes, then presents sign/zero-extended load data to the M→W read-data register. It also detects misaligned accesses and bus timeouts and reports them as faults.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit_load_extend.sv | 27 ++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline types for the memory stage: LSU states, funct3 access codes,
// fault causes and the captured bus-request payload.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } lsu_state_t;

  typedef enum logic {
    CAUSE_MISALIGN = 1'b0,
    CAUSE_ACCESS   = 1'b1
  } fault_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bus request captured in IDLE and replayed unchanged for the whole REQ phase
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } lsu_bus_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load data extraction: lane select by byte offset, then sign/zero extension by funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_data_c
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  always_comb begin
    byte_sh    = rdata >> {addr_lo, 3'b000};
    half_sh    = rdata >> {addr_lo[1], 4'b0000};
    ext_data_c = rdata;
    case (funct3)
      F3_B:    ext_data_c = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ext_data_c = {24'd0, byte_sh[7:0]};
      F3_H:    ext_data_c = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ext_data_c = {16'd0, half_sh[15:0]};
      default: ext_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: stalls the pipeline across a req/ack bus access and
// reports misaligned/timeout faults. LSU_MISALIGN_TRAP_EN traps misaligned H/W.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_read_m_i,
  input  logic              mem_write_m_i,
  input  logic [2:0]        funct3_m_i,
  input  logic [XLEN-1:0]   addr_m_i,
  input  logic [XLEN-1:0]   write_data_m_i,
  output logic              stall_m_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              misaligned_o,
  output logic              access_fault_o,
  output logic [XLEN-1:0]   fault_addr_o,
  load_store_unit_if.master bus
);

  lsu_state_t      state_q, state_d;
  fault_cause_t    cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lsu_bus_req_t    cap_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] fault_addr_d;
  logic            capture_en, rdata_en, fault_en;

  logic            mem_op, is_byte, is_half, trap_c;
  logic [XLEN-1:0] acc_addr;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] ext_c;

  assign mem_op = mem_read_m_i | mem_write_m_i;

  // Access decode: natural alignment (when not trapping) and store lane placement
  always_comb begin
    is_byte  = (funct3_m_i == F3_B) || (funct3_m_i == F3_BU);
    is_half  = (funct3_m_i == F3_H) || (funct3_m_i == F3_HU);
    acc_addr = addr_m_i;
    be_c     = 4'b1111;
    wdata_c  = '0;
`ifndef LSU_MISALIGN_TRAP_EN
    if (is_half)       acc_addr[0]   = 1'b0;
    else if (!is_byte) acc_addr[1:0] = 2'b00;
`endif
    if (mem_write_m_i) begin
      if (is_byte) begin
        be_c    = 4'b0001 << acc_addr[1:0];
        wdata_c = {4{write_data_m_i[7:0]}};
      end else if (is_half) begin
        be_c    = 4'b0011 << {acc_addr[1], 1'b0};
        wdata_c = {2{write_data_m_i[15:0]}};
      end else begin
        wdata_c = write_data_m_i;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_c = (is_half && addr_m_i[0]) || (!is_half && !is_byte && (addr_m_i[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  // Next-state and register-enable logic
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    capture_en   = 1'b0;
    rdata_en     = 1'b0;
    fault_en     = 1'b0;
    fault_addr_d = cap_q.addr;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          capture_en = 1'b1;
          if (trap_c) begin
            state_d      = FAULT;
            cause_d      = CAUSE_MISALIGN;
            fault_en     = 1'b1;
            fault_addr_d = acc_addr;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.bus_ack_i) begin
          rdata_en = 1'b1;
          state_d  = DONE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = FAULT;
          cause_d  = CAUSE_ACCESS;
          fault_en = 1'b1;
          cnt_d    = '0;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cause_q <= CAUSE_MISALIGN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_q        <= '0;
      f3_q         <= '0;
      rdata_q      <= '0;
      fault_addr_o <= '0;
    end else begin
      if (capture_en) begin
        cap_q.we    <= mem_write_m_i;
        cap_q.addr  <= acc_addr;
        cap_q.be    <= be_c;
        cap_q.wdata <= wdata_c;
        f3_q        <= funct3_m_i;
      end
      if (rdata_en) rdata_q      <= bus.bus_rdata_i;
      if (fault_en) fault_addr_o <= fault_addr_d;
    end
  end

  load_extend u_load_extend (
    .rdata      (rdata_q),
    .addr_lo    (cap_q.addr[1:0]),
    .funct3     (f3_q),
    .ext_data_c (ext_c)
  );

  // State-decoded outputs; the bus replays the captured request only while in REQ
  assign stall_m_o        = (state_q == REQ) || ((state_q == IDLE) && mem_op);
  assign load_data_o      = ((state_q == DONE) && !cap_q.we) ? ext_c : '0;
  assign access_fault_o   = (state_q == FAULT) && (cause_q == CAUSE_ACCESS);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned_o     = (state_q == FAULT) && (cause_q == CAUSE_MISALIGN);
`else
  assign misaligned_o     = 1'b0;
`endif
  assign bus.bus_req_o    = (state_q == REQ);
  assign bus.bus_we_o     = (state_q == REQ) && cap_q.we;
  assign bus.bus_addr_o   = (state_q == REQ) ? {cap_q.addr[XLEN-1:2], 2'b00} : '0;
  assign bus.bus_be_o     = (state_q == REQ) ? cap_q.be : '0;
  assign bus.bus_wdata_o  = (state_q == REQ) ? cap_q.wdata : '0;

endmodule
